// File: rtl/mips_mem_io.sv
// Data memory plus memory-mapped I/O (two latched input ports, one output port) for the multicycle MIPS.
// Build with MEM_ALIGN_CHECK_EN to add a sticky addr_err output that also suppresses misaligned accesses.
module mips_mem_io #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] INPORT0_ADDR = 32'hFFFF_FFF8,
  parameter logic [31:0] INPORT1_ADDR = 32'hFFFF_FFFC,
  parameter logic [31:0] OUTPORT_ADDR = 32'hFFFF_FFFC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [DATA_WIDTH-1:0] inport0_data,
  input  logic [DATA_WIDTH-1:0] inport1_data,
  input  logic                  inport0_en,
  input  logic                  inport1_en,
  output logic [DATA_WIDTH-1:0] outport,
  output logic                  outport_wr
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  addr_err
`endif
);

  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_IN0, SRC_IN1} src_e;

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] outport_q;
  logic                  outport_wr_q;
  logic [DATA_WIDTH-1:0] inport0_q, inport1_q;

  logic                  is_ram;
  logic                  aligned;
  logic [ADDR_WIDTH-1:0] idx;
  src_e                  rd_src;
  logic                  wr_ram, wr_out;

  // Exact compare against the RAM window: nothing above it aliases back into the array.
  assign is_ram = ((addr >> (ADDR_WIDTH + 2)) == 32'd0);
  assign idx    = addr[ADDR_WIDTH+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic addr_err_q;
  assign aligned  = (addr[1:0] == 2'b00);
  assign addr_err = addr_err_q;
`else
  assign aligned  = 1'b1;
`endif

  always_comb begin
    rd_src = SRC_NONE;
    if (addr == INPORT0_ADDR)      rd_src = SRC_IN0;
    else if (addr == INPORT1_ADDR) rd_src = SRC_IN1;
    else if (is_ram)               rd_src = SRC_RAM;
  end

  assign wr_ram = MemWrite && aligned && is_ram && (addr != OUTPORT_ADDR) && (addr != INPORT0_ADDR);
  assign wr_out = MemWrite && aligned && (addr == OUTPORT_ADDR);

  always_comb begin
    rd_data_d = rd_data_q;
    if (MemRead) begin
      if (!aligned) begin
        rd_data_d = '0;
      end else begin
        case (rd_src)
          SRC_RAM: rd_data_d = mem[idx];
          SRC_IN0: rd_data_d = inport0_q;
          SRC_IN1: rd_data_d = inport1_q;
          default: rd_data_d = '0;
        endcase
      end
    end
  end

  // RAM has no reset; the write is gated so an access in flight during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && wr_ram) mem[idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q    <= '0;
      outport_q    <= '0;
      outport_wr_q <= 1'b0;
      inport0_q    <= '0;
      inport1_q    <= '0;
    end else begin
      rd_data_q    <= rd_data_d;
      outport_wr_q <= wr_out;
      if (wr_out)     outport_q <= wr_data;
      if (inport0_en) inport0_q <= inport0_data;
      if (inport1_en) inport1_q <= inport1_data;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      addr_err_q <= 1'b0;
    else if ((MemRead || MemWrite) && !aligned)    addr_err_q <= 1'b1;
  end
`endif

  assign rd_data    = rd_data_q;
  assign outport    = outport_q;
  assign outport_wr = outport_wr_q;

endmodule
